// File: rtl/key_debounce_reader_if.sv
// Key pin and debounced event bundle between board pins and application logic.
interface key_debounce_reader_if #(
  parameter int KEY_NUM = 4
);
  logic [KEY_NUM-1:0] key_in;
  logic [KEY_NUM-1:0] key_level;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] key_release;
  logic [KEY_NUM-1:0] key_long;

  modport master (output key_in, input key_level, key_press, key_release, key_long);
  modport slave  (input key_in, output key_level, key_press, key_release, key_long);
endinterface

// File: rtl/key_debounce_reader.sv
// Per-key synchroniser, debounce FSM and hold timer; one lane instance per key.
module key_db_lane #(
  parameter bit ACT_LOW  = 1'b1,
  parameter int DB_CNT   = 240_000,
  parameter int LONG_CNT = 12_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic press,
  output logic rel,
  output logic lng
);
  localparam int DW = $clog2(DB_CNT);
  localparam int HW = $clog2(LONG_CNT);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CNT - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CNT - 1);

  typedef enum logic [2:0] {IDLE, PRESS_DB, PRESSED, LONG_HELD, RELEASE_DB} state_t;

  state_t        state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic          from_long, from_long_n;
  logic          level_n, press_n, rel_n, lng_n;
  logic          sync1, sync2;
  logic          act;

  // Synchroniser idles at the released pin level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= ACT_LOW;
      sync2 <= ACT_LOW;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  assign act = sync2 ^ ACT_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dcnt      <= '0;
      hcnt      <= '0;
      from_long <= 1'b0;
      level     <= 1'b0;
      press     <= 1'b0;
      rel       <= 1'b0;
      lng       <= 1'b0;
    end else begin
      state     <= state_n;
      dcnt      <= dcnt_n;
      hcnt      <= hcnt_n;
      from_long <= from_long_n;
      level     <= level_n;
      press     <= press_n;
      rel       <= rel_n;
      lng       <= lng_n;
    end
  end

  always_comb begin
    state_n     = state;
    dcnt_n      = dcnt;
    hcnt_n      = hcnt;
    from_long_n = from_long;
    level_n     = level;
    press_n     = 1'b0;
    rel_n       = 1'b0;
    lng_n       = 1'b0;
    case (state)
      IDLE: if (act) begin
        state_n = PRESS_DB;
        dcnt_n  = '0;
      end
      PRESS_DB: begin
        if (!act) state_n = IDLE;
        else if (dcnt == DB_LAST) begin
          state_n = PRESSED;
          level_n = 1'b1;
          press_n = 1'b1;
          hcnt_n  = '0;
        end else dcnt_n = dcnt + DW'(1);
      end
      PRESSED: begin
        // A release bounce leaves hcnt frozen; it resumes on return.
        if (!act) begin
          state_n     = RELEASE_DB;
          dcnt_n      = '0;
          from_long_n = 1'b0;
        end else if (hcnt == LONG_LAST) begin
          state_n = LONG_HELD;
          lng_n   = 1'b1;
        end else hcnt_n = hcnt + HW'(1);
      end
      LONG_HELD: if (!act) begin
        state_n     = RELEASE_DB;
        dcnt_n      = '0;
        from_long_n = 1'b1;
      end
      RELEASE_DB: begin
        if (act) state_n = from_long ? LONG_HELD : PRESSED;
        else if (dcnt == DB_LAST) begin
          state_n = IDLE;
          level_n = 1'b0;
          rel_n   = 1'b1;
        end else dcnt_n = dcnt + DW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

module key_debounce_reader #(
  parameter int KEY_NUM        = 4,
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int DB_CNT         = 240_000,
  parameter int LONG_CNT       = 12_000_000
) (
  input logic clk,
  input logic rst,
  key_debounce_reader_if.slave kif
);
  for (genvar i = 0; i < KEY_NUM; i++) begin : g_lane
    key_db_lane #(
      .ACT_LOW (KEY_ACTIVE_LOW),
      .DB_CNT  (DB_CNT),
      .LONG_CNT(LONG_CNT)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .pin  (kif.key_in[i]),
      .level(kif.key_level[i]),
      .press(kif.key_press[i]),
      .rel  (kif.key_release[i]),
      .lng  (kif.key_long[i])
    );
  end
endmodule

// File: tb/tb_key_debounce_reader.sv
// Scoreboarded bench: every expected strobe is queued with its cycle when the pins change.
module tb_key_debounce_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    int         at;
    logic [1:0] p;
    logic [1:0] r;
    logic [1:0] l;
  } ev_t;
  ev_t q[$];

  key_debounce_reader_if #(.KEY_NUM(2)) kif ();

  key_debounce_reader #(
    .KEY_NUM(2), .KEY_ACTIVE_LOW(1'b1), .DB_CNT(4), .LONG_CNT(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kif(kif)
  );

  always #5 clk = ~clk;

  function automatic ev_t mk(int at, logic [1:0] p, logic [1:0] r, logic [1:0] l);
    ev_t e;
    e.at = at; e.p = p; e.r = r; e.l = l;
    return e;
  endfunction

  // Advance one cycle and match any strobe against the scoreboard head.
  task automatic tick();
    ev_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (|{kif.key_press, kif.key_release, kif.key_long}) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe cyc=%0d press=%b release=%b long=%b", cyc,
                 kif.key_press, kif.key_release, kif.key_long);
      end else begin
        e = q.pop_front();
        if (cyc !== e.at || kif.key_press !== e.p || kif.key_release !== e.r ||
            kif.key_long !== e.l) begin
          bad++;
          $display("FAIL strobe cyc=%0d press=%b release=%b long=%b expected cyc=%0d press=%b release=%b long=%b",
                   cyc, kif.key_press, kif.key_release, kif.key_long, e.at, e.p, e.r, e.l);
        end
      end
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(string name);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing pending=%0d next_cyc=%0d now=%0d", name, q.size(), q[0].at, cyc);
      q.delete();
    end
  endtask

  task automatic chk_level(string name, logic [1:0] exp);
    total++;
    if (kif.key_level !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d key_level=%b expected=%b", name, cyc, kif.key_level, exp);
    end
  endtask

  task automatic test_reset();
    kif.key_in = 2'b11;
    rst = 1'b1;
    ticks(3);
    total++;
    if ({kif.key_level, kif.key_press, kif.key_release, kif.key_long} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got=%h expected=00",
               {kif.key_level, kif.key_press, kif.key_release, kif.key_long});
    end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (kif.key_level !== 2'b00) chk_level("reset_idle_level", 2'b00);
    end
    chk_level("reset_idle_level_end", 2'b00);
    drain("reset");
  endtask

  task automatic test_clean_press();
    q.push_back(mk(cyc + 7, 2'b01, 2'b00, 2'b00));
    kif.key_in[0] = 1'b0;
    ticks(6);
    chk_level("press_level_before", 2'b00);
    tick();
    chk_level("press_level_after", 2'b01);
    ticks(3);
    chk_level("press_level_held", 2'b01);
    q.push_back(mk(cyc + 7, 2'b00, 2'b01, 2'b00));
    kif.key_in[0] = 1'b1;
    ticks(6);
    chk_level("release_level_before", 2'b01);
    tick();
    chk_level("release_level_after", 2'b00);
    ticks(3);
    drain("clean_press");
  endtask

  task automatic test_bounce();
    kif.key_in[0] = 1'b0; ticks(3);
    kif.key_in[0] = 1'b1; ticks(2);
    kif.key_in[0] = 1'b0; ticks(2);
    kif.key_in[0] = 1'b1; ticks(10);
    chk_level("bounce_level", 2'b00);
    drain("bounce_quiet");
    q.push_back(mk(cyc + 7, 2'b01, 2'b00, 2'b00));
    kif.key_in[0] = 1'b0;
    ticks(10);
    chk_level("bounce_then_press", 2'b01);
    q.push_back(mk(cyc + 7, 2'b00, 2'b01, 2'b00));
    kif.key_in[0] = 1'b1;
    ticks(10);
    drain("bounce");
  endtask

  task automatic test_long_press();
    q.push_back(mk(cyc + 7, 2'b10, 2'b00, 2'b00));
    q.push_back(mk(cyc + 27, 2'b00, 2'b00, 2'b10));
    kif.key_in[1] = 1'b0;
    ticks(40);
    chk_level("long_level", 2'b10);
    q.push_back(mk(cyc + 7, 2'b00, 2'b10, 2'b00));
    kif.key_in[1] = 1'b1;
    ticks(10);
    chk_level("long_released", 2'b00);
    drain("long_press");
  endtask

  task automatic test_release_bounce();
    int p;
    p = cyc + 7;
    q.push_back(mk(p, 2'b01, 2'b00, 2'b00));
    kif.key_in[0] = 1'b0;
    ticks(10);
    kif.key_in[0] = 1'b1; ticks(2);
    kif.key_in[0] = 1'b0; ticks(6);
    chk_level("relbounce_level", 2'b01);
    // Three frozen hold cycles push the long strobe out by three.
    q.push_back(mk(p + 23, 2'b00, 2'b00, 2'b01));
    while (cyc < p + 25) tick();
    q.push_back(mk(cyc + 7, 2'b00, 2'b01, 2'b00));
    kif.key_in[0] = 1'b1;
    ticks(10);
    drain("release_bounce");
  endtask

  task automatic test_both_reset();
    q.push_back(mk(cyc + 7, 2'b11, 2'b00, 2'b00));
    kif.key_in = 2'b00;
    ticks(10);
    chk_level("both_level", 2'b11);
    drain("both_press");
    rst = 1'b1;
    #1;
    total++;
    if ({kif.key_level, kif.key_press, kif.key_release, kif.key_long} !== 8'h00) begin
      bad++;
      $display("FAIL midreset_clear got=%h expected=00",
               {kif.key_level, kif.key_press, kif.key_release, kif.key_long});
    end
    ticks(2);
    rst = 1'b0;
    q.push_back(mk(cyc + 7, 2'b11, 2'b00, 2'b00));
    ticks(6);
    chk_level("after_reset_before", 2'b00);
    tick();
    chk_level("after_reset_press", 2'b11);
    ticks(3);
    q.push_back(mk(cyc + 7, 2'b00, 2'b11, 2'b00));
    kif.key_in = 2'b11;
    ticks(10);
    chk_level("both_released", 2'b00);
    drain("both_reset");
  endtask

  initial begin
    kif.key_in = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_release_bounce();
    test_both_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
